pc_fetch_unit: RTL
==================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have port CLK  input  1  rising-edge system clock.
REQ-002 SHALL have port Reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-003 SHALL have port PCSrc  input  2  next-PC select from control unit: 00 seq, 01 branch, 10 jump, 11 seq.
REQ-004 SHALL have port PCWrite  input  1  1 = advance PC; 0 = halt instruction.
REQ-005 SHALL have port imm_ext  input  32  sign/zero-extended immediate (branch word offset).
REQ-006 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-007 SHALL have port imem_addr  output  32  byte address of the requested instruction.
REQ-008 SHALL have port imem_ack  input  1  read data valid this cycle.
REQ-009 SHALL have port imem_rdata  input  32  instruction word.
REQ-010 SHALL have port instr  output  32  latched current instruction.
REQ-011 SHALL have port op  output  6  instr[31:26], drives control-unit op.
REQ-012 SHALL have port instr_valid  output  1  instr/op stable, control outputs sampled this cycle.
REQ-013 SHALL have port PC  output  32  address of current instruction.
REQ-014 SHALL have port halted  output  1  block in HALT state.
REQ-015 SHALL have port fetch_err  output  1  fetch timeout flag (FETCH_TIMEOUT_EN only; tied 0 otherwise).

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, ISSUE, HALT.
REQ-017 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-018 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal PC; imem_req SHALL be 0 in all other states.
REQ-019 On imem_ack=1 in FETCH, instr SHALL capture imem_rdata at that edge and FSM SHALL go to ISSUE; ack in other states SHALL be ignored.
REQ-020 FETCH SHALL hold with imem_req=1 and unchanged imem_addr while imem_ack=0.
REQ-021 instr_valid SHALL be 1 only in ISSUE (exactly one cycle per instruction).
REQ-022 At the ISSUE edge with PCWrite=1: PC SHALL load next-PC and FSM SHALL go to FETCH.
REQ-023 Next-PC: PC4=PC+4; 00/11 -> PC4; 01 -> PC4 + (imm_ext<<2); 10 -> {PC4[31:28], instr[25:0], 2'b00}; all mod 2^32, carries discarded.
REQ-024 At the ISSUE edge with PCWrite=0: PC SHALL hold, FSM SHALL go to HALT.
REQ-025 HALT SHALL be terminal until Reset; halted=1 only in HALT.
REQ-026 PCSrc/PCWrite/imm_ext SHALL be sampled only at the ISSUE edge; values in other states have no effect.
REQ-027 Minimum throughput SHALL be one instruction per 2 cycles (FETCH with same-cycle ack, ISSUE).

Reset
REQ-028 Reset=0 SHALL immediately force: state IDLE, PC=0x00000000, instr=0, imem_req=0, instr_valid=0, halted=0, fetch_err=0, timeout counter=0.
REQ-029 Reset asserted mid-FETCH SHALL drop imem_req asynchronously; any later ack for the aborted request SHALL be ignored.
REQ-030 Reset release SHALL be synchronized only by the first rising CLK edge; no outputs change before it.

Configuration
REQ-031 Macro FETCH_TIMEOUT_EN defined: a 4-bit counter SHALL count FETCH cycles without ack, clear on entering FETCH; on the 16th consecutive waiting cycle the FSM SHALL go to HALT and set fetch_err=1 (sticky until Reset).
REQ-032 Macro FETCH_TIMEOUT_EN undefined: no counter, FETCH waits indefinitely, fetch_err constant 0.

Verification
REQ-033 Reset release, ack same cycle, rdata=0x20010005, PCSrc=00, PCWrite=1 -> imem_addr=0x0 in FETCH, op=0x08, instr_valid one cycle, next imem_addr=0x4.
REQ-034 PC=0x10, PCSrc=01, imem_ext=0xFFFFFFFE -> next PC=0x0C; imm_ext=0x3 -> next PC=0x20.
REQ-035 PC=0xF0000008, instr[25:0]=0x0000010, PCSrc=10 -> next PC=0xF0000040.
REQ-036 ISSUE with op=0x3F, PCWrite=0 -> PC holds, halted=1, imem_req stays 0 for 20 cycles, ack pulses ignored.
REQ-037 ack delayed 5 cycles -> imem_req/imem_addr stable 6 cycles, instr_valid after ack; Reset pulse mid-wait -> imem_req=0 immediately, PC=0, IDLE.
REQ-038 FETCH_TIMEOUT_EN defined, no ack -> after 16 wait cycles halted=1, fetch_err=1; undefined -> still in FETCH after 100 cycles, fetch_err=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction fetch sequencer: owns the PC, requests words from instruction memory
// and presents one instruction at a time. Optional fetch timeout via FETCH_TIMEOUT_EN.
module pc_fetch_unit (
   input  logic        CLK,
   input  logic        Reset,
   input  logic [1:0]  PCSrc,
   input  logic        PCWrite,
   input  logic [31:0] imm_ext,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [5:0]  op,
   output logic        instr_valid,
   output logic [31:0] PC,
   output logic        halted,
   output logic        fetch_err,
   output logic [1:0]  fsm_state
);

   // Memory handshake: imem_req is held high for the whole FETCH state and the
   // address is stable until imem_ack is seen high at a rising edge; ack outside
   // FETCH (including one belonging to a request aborted by reset) is ignored.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_ISSUE = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t      state;
   logic [31:0] pc4;
   logic [31:0] next_pc;

`ifdef FETCH_TIMEOUT_EN
   logic [3:0]  wait_cnt;
   logic        fetch_err_q;
   assign fetch_err = fetch_err_q;
`else
   assign fetch_err = 1'b0;
`endif

   assign imem_addr = PC;
   assign op        = instr[31:26];
   assign fsm_state = state;

   always_comb begin
      pc4     = PC + 32'd4;
      next_pc = pc4;
      case (PCSrc)
         2'b01:   next_pc = pc4 + (imm_ext << 2);
         2'b10:   next_pc = {pc4[31:28], instr[25:0], 2'b00};
         default: next_pc = pc4;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state       <= S_IDLE;
         PC          <= '0;
         instr       <= '0;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
         wait_cnt    <= '0;
         fetch_err_q <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               state    <= S_FETCH;
               imem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            S_FETCH: begin
               if (imem_ack) begin
                  instr       <= imem_rdata;
                  state       <= S_ISSUE;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
               end
`ifdef FETCH_TIMEOUT_EN
               // sixteenth consecutive edge without ack gives up for good
               else if (wait_cnt == 4'd15) begin
                  state       <= S_HALT;
                  imem_req    <= 1'b0;
                  halted      <= 1'b1;
                  fetch_err_q <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
`endif
            end
            S_ISSUE: begin
               instr_valid <= 1'b0;
               if (PCWrite) begin
                  PC       <= next_pc;
                  state    <= S_FETCH;
                  imem_req <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                  wait_cnt <= '0;
`endif
               end else begin
                  state  <= S_HALT;
                  halted <= 1'b1;
               end
            end
            default: begin
               state <= S_HALT;
            end
         endcase
      end
   end

endmodule
